// File: rtl/gen_bus_mem_arbiter.sv
// Arbitrates the icache and dcache memory-side ports onto one generic bus.
// Grants are registered and held for a whole transaction; dcache has priority, bounded by a starvation counter.
module gen_bus_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic                i_ren,
  input  logic                d_ren,
  input  logic                i_wen,
  input  logic                d_wen,
  input  logic [DATA_W/8-1:0] i_byte_en,
  input  logic [DATA_W/8-1:0] d_byte_en,
  output logic [DATA_W-1:0]   i_rdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                i_busy,
  output logic                d_busy,
  output logic [ADDR_W-1:0]   out_addr,
  output logic [DATA_W-1:0]   out_wdata,
  output logic [DATA_W/8-1:0] out_byte_en,
  output logic                out_ren,
  output logic                out_wen,
  input  logic [DATA_W-1:0]   out_rdata,
  input  logic                out_busy,
  output logic [1:0]          grant
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic             i_pend;
  logic             d_pend;
  logic             take_i;
  logic             take_d;

  assign i_pend = i_ren | i_wen;
  assign d_pend = d_ren | d_wen;
  assign take_i = (state == IDLE) && (state_nxt == GNT_I);
  assign take_d = (state == IDLE) && (state_nxt == GNT_D);

  always_ff @(posedge CLK) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  // icache only beats a pending dcache once it has waited STARVE_LIMIT cycles
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_pend && (!d_pend || (starve_cnt == LIMIT))) state_nxt = GNT_I;
        else if (d_pend)                                  state_nxt = GNT_D;
      end
      GNT_I, GNT_D: begin
        if (!out_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant  = 2'b00;
    i_busy = 1'b1;
    d_busy = 1'b1;
    case (state)
      GNT_I: begin
        grant  = 2'b01;
        i_busy = out_busy;
      end
      GNT_D: begin
        grant  = 2'b10;
        d_busy = out_busy;
      end
      default: grant = 2'b00;
    endcase
  end

  assign i_rdata = out_rdata;
  assign d_rdata = out_rdata;

  // Write wins over read when a requester raises both.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      out_addr    <= '0;
      out_wdata   <= '0;
      out_byte_en <= '0;
      out_ren     <= 1'b0;
      out_wen     <= 1'b0;
    end else if (take_i) begin
      out_addr    <= i_addr;
      out_wdata   <= i_wdata;
      out_byte_en <= i_byte_en;
      out_ren     <= i_ren & ~i_wen;
      out_wen     <= i_wen;
    end else if (take_d) begin
      out_addr    <= d_addr;
      out_wdata   <= d_wdata;
      out_byte_en <= d_byte_en;
      out_ren     <= d_ren & ~d_wen;
      out_wen     <= d_wen;
    end else if ((state != IDLE) && !out_busy) begin
      out_ren <= 1'b0;
      out_wen <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST)                                     starve_cnt <= '0;
    else if (!i_pend)                              starve_cnt <= '0;
    else if (take_i)                               starve_cnt <= '0;
    else if ((state != GNT_I) && (starve_cnt != LIMIT)) starve_cnt <= starve_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_gen_bus_mem_arbiter.sv
// Bench for gen_bus_mem_arbiter: vector table of single transactions plus hand-built
// sequences for contention, starvation and reset; completions are scored against a queue.
module tb_gen_bus_mem_arbiter;

  logic        CLK;
  logic        nRST;
  logic [31:0] i_addr, d_addr, i_wdata, d_wdata;
  logic        i_ren, d_ren, i_wen, d_wen;
  logic [3:0]  i_byte_en, d_byte_en;
  logic [31:0] i_rdata, d_rdata;
  logic        i_busy, d_busy;
  logic [31:0] out_addr, out_wdata;
  logic [3:0]  out_byte_en;
  logic        out_ren, out_wen;
  logic [31:0] out_rdata;
  logic        out_busy;
  logic [1:0]  grant;

  gen_bus_mem_arbiter #(.STARVE_LIMIT(4), .ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .i_addr(i_addr), .d_addr(d_addr), .i_wdata(i_wdata), .d_wdata(d_wdata),
    .i_ren(i_ren), .d_ren(d_ren), .i_wen(i_wen), .d_wen(d_wen),
    .i_byte_en(i_byte_en), .d_byte_en(d_byte_en),
    .i_rdata(i_rdata), .d_rdata(d_rdata), .i_busy(i_busy), .d_busy(d_busy),
    .out_addr(out_addr), .out_wdata(out_wdata), .out_byte_en(out_byte_en),
    .out_ren(out_ren), .out_wen(out_wen), .out_rdata(out_rdata),
    .out_busy(out_busy), .grant(grant)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        is_d;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          waits;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ren;
    logic        wen;
    logic [31:0] rdata;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  int   i_done = 0;
  int   d_done = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic is_d, input logic ren, input logic wen,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] be, input logic [31:0] rdata);
    exp_t e;
    e.is_d  = is_d;
    e.addr  = addr;
    e.wdata = wdata;
    e.be    = be;
    e.ren   = ren & ~wen;
    e.wen   = wen;
    e.rdata = rdata;
    return e;
  endfunction

  task automatic drive_req(input logic is_d, input logic ren, input logic wen,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    if (is_d) begin
      d_ren = ren; d_wen = wen; d_addr = addr; d_wdata = wdata; d_byte_en = be;
    end else begin
      i_ren = ren; i_wen = wen; i_addr = addr; i_wdata = wdata; i_byte_en = be;
    end
  endtask

  task automatic clear_reqs();
    i_ren = 0; i_wen = 0; d_ren = 0; d_wen = 0;
  endtask

  // Completion monitor: every busy-low cycle must match the oldest expected transaction.
  always @(negedge CLK) begin
    check("busy_exclusive", {63'd0, (!i_busy && !d_busy)}, 64'd0);
    check("ren_wen_exclusive", {63'd0, (out_ren && out_wen)}, 64'd0);
    if (!i_busy || !d_busy) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_completion i_busy=%0b d_busy=%0b expected=none", i_busy, d_busy);
      end else begin
        mon_e = sb.pop_front();
        if (!d_busy) d_done++;
        if (!i_busy) i_done++;
        check("cmp_owner_d", {63'd0, !d_busy}, {63'd0, mon_e.is_d});
        check("cmp_grant", grant, mon_e.is_d ? 64'd2 : 64'd1);
        check("cmp_addr", out_addr, mon_e.addr);
        check("cmp_wdata", out_wdata, mon_e.wdata);
        check("cmp_byte_en", out_byte_en, mon_e.be);
        check("cmp_ren", out_ren, mon_e.ren);
        check("cmp_wen", out_wen, mon_e.wen);
        check("cmp_rdata", mon_e.is_d ? d_rdata : i_rdata, mon_e.rdata);
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int  w;
    bit  ok;
    @(posedge CLK); #1;
    drive_req(v.is_d, v.ren, v.wen, v.addr, v.wdata, v.be);
    out_busy  = 1'b1;
    out_rdata = v.rdata;
    sb.push_back(mk_exp(v.is_d, v.ren, v.wen, v.addr, v.wdata, v.be, v.rdata));
    w  = 0;
    ok = 0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(posedge CLK); #1;
      if (c == 0) begin
        check("lat_grant", grant, v.is_d ? 64'd2 : 64'd1);
        check("lat_out_ren", out_ren, v.ren & ~v.wen);
        check("lat_out_wen", out_wen, v.wen);
        drive_req(v.is_d, v.ren, v.wen, v.addr ^ 32'h0000_1000, ~v.wdata, ~v.be);
      end
      if (grant != 2'b00) begin
        if (w == v.waits) begin
          out_busy = 1'b0;
          ok = 1;
        end else begin
          out_busy = 1'b1;
        end
        w++;
      end
    end
    if (!ok) check("vec_timeout", 64'd1, 64'd0);
    @(posedge CLK); #1;
    clear_reqs();
    out_busy = 1'b1;
    check("idle_after_done", grant, 64'd0);
    check("out_req_cleared", {62'd0, out_ren, out_wen}, 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int          dn0, in0, max_cnt, gc;
    bit          done, first_i;

    vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h0000_4000, 32'h0,          4'hF, 0, 32'hA5A5_0001};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_0104, 32'h0,          4'hF, 1, 32'h1111_2222};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h0000_2000, 32'h1234_5678,  4'hF, 2, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'hCAFE_F00D,  4'h3, 0, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF,  4'h8, 3, 32'h0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'h0,          4'h5, 1, 32'h0BAD_F00D};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h5555_AAAA,  4'hF, 1, 32'h0};

    nRST = 0;
    clear_reqs();
    i_addr = 0; d_addr = 0; i_wdata = 0; d_wdata = 0; i_byte_en = 0; d_byte_en = 0;
    out_rdata = 0;
    out_busy = 1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_grant", grant, 64'd0);
    check("rst_i_busy", i_busy, 64'd1);
    check("rst_d_busy", d_busy, 64'd1);
    check("rst_out_req", {62'd0, out_ren, out_wen}, 64'd0);
    check("rst_out_addr", out_addr, 64'd0);
    check("rst_out_fields", {28'd0, out_byte_en, out_wdata}, 64'd0);
    check("rst_starve_cnt", dut.starve_cnt, 64'd0);
    @(posedge CLK); #1;
    nRST = 1;

    // icache read with zero-wait downstream
    @(posedge CLK); #1;
    drive_req(1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
    out_busy  = 1'b0;
    out_rdata = 32'hDEAD_BEEF;
    sb.push_back(mk_exp(1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 32'hDEAD_BEEF));
    @(negedge CLK);
    check("t1_c0_grant", grant, 64'd0);
    check("t1_c0_i_busy", i_busy, 64'd1);
    @(posedge CLK); #1;
    check("t1_c1_out_ren", out_ren, 64'd1);
    check("t1_c1_out_addr", out_addr, 64'h100);
    check("t1_c1_grant", grant, 64'd1);
    @(negedge CLK);
    check("t1_c1_i_busy", i_busy, 64'd0);
    check("t1_c1_i_rdata", i_rdata, 64'hDEAD_BEEF);
    @(posedge CLK); #1;
    clear_reqs();
    out_busy = 1'b1;
    check("t1_c2_grant", grant, 64'd0);
    check("t1_c2_out_ren", out_ren, 64'd0);

    foreach (vecs[k]) run_vec(vecs[k]);

    // simultaneous requests: dcache first, one IDLE cycle, then icache
    dn0 = d_done;
    in0 = i_done;
    @(posedge CLK); #1;
    drive_req(1'b0, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 4'hF);
    drive_req(1'b1, 1'b1, 1'b0, 32'h0000_0600, 32'h0, 4'hF);
    out_busy  = 1'b0;
    out_rdata = 32'h0D0D_0D0D;
    sb.push_back(mk_exp(1'b1, 1'b1, 1'b0, 32'h0000_0600, 32'h0, 4'hF, 32'h0D0D_0D0D));
    sb.push_back(mk_exp(1'b0, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 4'hF, 32'h1C1C_1C1C));
    @(posedge CLK); #1;
    check("sim_c1_grant", grant, 64'd2);
    d_ren = 0;
    @(posedge CLK); #1;
    check("sim_c2_grant", grant, 64'd0);
    out_rdata = 32'h1C1C_1C1C;
    @(posedge CLK); #1;
    check("sim_c3_grant", grant, 64'd1);
    @(posedge CLK); #1;
    i_ren = 0;
    out_busy = 1'b1;
    check("sim_c4_grant", grant, 64'd0);
    @(posedge CLK); #1;
    check("sim_d_done_once", d_done - dn0, 64'd1);
    check("sim_i_done_once", i_done - in0, 64'd1);

    // starvation: dcache always pending, one wait cycle per transaction
    dn0 = d_done;
    @(posedge CLK); #1;
    drive_req(1'b0, 1'b1, 1'b0, 32'h0000_0700, 32'h0, 4'hF);
    drive_req(1'b1, 1'b1, 1'b0, 32'h0000_0800, 32'h0, 4'hF);
    out_busy  = 1'b1;
    out_rdata = 32'h0000_0077;
    sb.push_back(mk_exp(1'b1, 1'b1, 1'b0, 32'h0000_0800, 32'h0, 4'hF, 32'h77));
    sb.push_back(mk_exp(1'b1, 1'b1, 1'b0, 32'h0000_0800, 32'h0, 4'hF, 32'h77));
    sb.push_back(mk_exp(1'b0, 1'b1, 1'b0, 32'h0000_0700, 32'h0, 4'hF, 32'h77));
    max_cnt = 0;
    gc = 0;
    done = 0;
    first_i = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(posedge CLK); #1;
      if (int'(dut.starve_cnt) > max_cnt) max_cnt = int'(dut.starve_cnt);
      if (grant == 2'b01 && !first_i) begin
        first_i = 1;
        check("starve_cnt_cleared", dut.starve_cnt, 64'd0);
        check("starve_d_before_i", d_done - dn0, 64'd2);
      end
      if (grant != 2'b00) begin
        if (gc == 0) begin
          out_busy = 1'b1;
          gc = 1;
        end else begin
          out_busy = 1'b0;
          gc = 0;
          if (grant == 2'b01) done = 1;
        end
      end else begin
        gc = 0;
      end
    end
    @(posedge CLK); #1;
    clear_reqs();
    out_busy = 1'b1;
    check("starve_icache_served", {63'd0, done}, 64'd1);
    check("starve_cnt_peak", max_cnt, 64'd4);

    // reset during a dcache write that is still busy
    @(posedge CLK); #1;
    drive_req(1'b1, 1'b0, 1'b1, 32'h0000_0900, 32'hABCD_0123, 4'hF);
    drive_req(1'b0, 1'b1, 1'b0, 32'h0000_0A00, 32'h0, 4'hF);
    out_busy = 1'b1;
    @(posedge CLK); #1;
    check("rstx_pre_grant", grant, 64'd2);
    check("rstx_pre_out_wen", out_wen, 64'd1);
    nRST = 0;
    @(posedge CLK); #1;
    check("rstx_grant", grant, 64'd0);
    check("rstx_out_wen", out_wen, 64'd0);
    check("rstx_d_busy", d_busy, 64'd1);
    check("rstx_starve_cnt", dut.starve_cnt, 64'd0);
    clear_reqs();
    nRST = 1;
    out_busy = 1'b0;
    repeat (5) begin
      @(posedge CLK); #1;
      check("rstx_stays_idle", grant, 64'd0);
    end
    out_busy = 1'b1;
    check("scoreboard_drained", sb.size(), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
